// File: rtl/hpc2_and_scheduler.sv
// Round-robin front end that time-shares one 4-share HPC2 AND gadget between two
// requesters, feeding each operation a fresh randomness word and routing results back.
module hpc2_and_scheduler #(
    parameter int SHARES = 4,
    parameter int RAND_W = 6,
    parameter int LAT    = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clock_0,
    input  logic              reset_0,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [SHARES-1:0] req0_a,
    input  logic [SHARES-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [SHARES-1:0] req1_a,
    input  logic [SHARES-1:0] req1_b,
    input  logic              rnd_valid,
    output logic              rnd_ready,
    input  logic [RAND_W-1:0] rnd_data,
    output logic [SHARES-1:0] g_a,
    output logic [SHARES-1:0] g_b,
    output logic [RAND_W-1:0] g_rand,
    input  logic [SHARES-1:0] g_z,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [SHARES-1:0] rsp0_z,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [SHARES-1:0] rsp1_z,
    output logic [CNT_W-1:0]  starve_cnt
);

    logic              rr_q, rr_d;
    logic [LAT-1:0]    pipe_v_q, pipe_v_d;
    logic [LAT-1:0]    pipe_tag_q, pipe_tag_d;
    logic [1:0]        slot_v_q, slot_v_d;
    logic [SHARES-1:0] slot0_z_q, slot0_z_d;
    logic [SHARES-1:0] slot1_z_q, slot1_z_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [1:0]        busy_s;
    logic [1:0]        drain_s;
    logic [1:0]        elig_s;
    logic              grant_v_s;
    logic              grant_id_s;
    logic              issue_s;
    logic              cap0_s;
    logic              cap1_s;

    // Arbitration, issue gating and next-state for every register.
    always_comb begin
        busy_s     = 2'b00;
        grant_v_s  = 1'b0;
        grant_id_s = 1'b0;
        pipe_v_d   = pipe_v_q;
        pipe_tag_d = pipe_tag_q;
        cnt_d      = cnt_q;

        for (int k = 0; k < LAT; k++) begin
            busy_s[0] = busy_s[0] | (pipe_v_q[k] & ~pipe_tag_q[k]);
            busy_s[1] = busy_s[1] | (pipe_v_q[k] &  pipe_tag_q[k]);
        end

        drain_s[0] = slot_v_q[0] & rsp0_ready;
        drain_s[1] = slot_v_q[1] & rsp1_ready;
        // A draining slot frees up in time for a new result LAT+1 cycles later.
        elig_s[0]  = req0_valid & (~slot_v_q[0] | drain_s[0]) & ~busy_s[0];
        elig_s[1]  = req1_valid & (~slot_v_q[1] | drain_s[1]) & ~busy_s[1];

        case (elig_s)
            2'b11: begin
                grant_v_s  = 1'b1;
                grant_id_s = rr_q;
            end
            2'b01: begin
                grant_v_s  = 1'b1;
                grant_id_s = 1'b0;
            end
            2'b10: begin
                grant_v_s  = 1'b1;
                grant_id_s = 1'b1;
            end
            default: begin
                grant_v_s  = 1'b0;
                grant_id_s = 1'b0;
            end
        endcase

        issue_s = grant_v_s & rnd_valid;

        // Gadget inputs are zero unless an operation is issued this very cycle.
        if (issue_s) begin
            g_a    = grant_id_s ? req1_a : req0_a;
            g_b    = grant_id_s ? req1_b : req0_b;
            g_rand = rnd_data;
            rr_d   = ~grant_id_s;
        end else begin
            g_a    = {SHARES{1'b0}};
            g_b    = {SHARES{1'b0}};
            g_rand = {RAND_W{1'b0}};
            rr_d   = rr_q;
        end

        req0_ready = issue_s & ~grant_id_s;
        req1_ready = issue_s &  grant_id_s;
        rnd_ready  = issue_s;

        pipe_v_d[0]   = issue_s;
        pipe_tag_d[0] = grant_id_s;
        for (int k = 1; k < LAT; k++) begin
            pipe_v_d[k]   = pipe_v_q[k-1];
            pipe_tag_d[k] = pipe_tag_q[k-1];
        end

        cap0_s = pipe_v_q[LAT-1] & ~pipe_tag_q[LAT-1];
        cap1_s = pipe_v_q[LAT-1] &  pipe_tag_q[LAT-1];

        slot_v_d[0] = (slot_v_q[0] & ~drain_s[0]) | cap0_s;
        slot_v_d[1] = (slot_v_q[1] & ~drain_s[1]) | cap1_s;
        slot0_z_d   = cap0_s ? g_z : slot0_z_q;
        slot1_z_d   = cap1_s ? g_z : slot1_z_q;

        if (grant_v_s && !rnd_valid && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers; reset empties the pipe so in-flight results are dropped.
    always_ff @(posedge clock_0 or negedge reset_0) begin
        if (!reset_0) begin
            rr_q       <= 1'b0;
            pipe_v_q   <= {LAT{1'b0}};
            pipe_tag_q <= {LAT{1'b0}};
            slot_v_q   <= 2'b00;
            slot0_z_q  <= {SHARES{1'b0}};
            slot1_z_q  <= {SHARES{1'b0}};
            cnt_q      <= {CNT_W{1'b0}};
        end else begin
            rr_q       <= rr_d;
            pipe_v_q   <= pipe_v_d;
            pipe_tag_q <= pipe_tag_d;
            slot_v_q   <= slot_v_d;
            slot0_z_q  <= slot0_z_d;
            slot1_z_q  <= slot1_z_d;
            cnt_q      <= cnt_d;
        end
    end

    assign rsp0_valid = slot_v_q[0];
    assign rsp1_valid = slot_v_q[1];
    assign rsp0_z     = slot0_z_q;
    assign rsp1_z     = slot1_z_q;
    assign starve_cnt = cnt_q;

endmodule

// File: tb/tb_hpc2_and_scheduler.sv
// Randomized and directed bench for hpc2_and_scheduler with a timestamp-based
// reference model and a behavioural 4-share AND gadget with one cycle of latency.
module tb_hpc2_and_scheduler;

    localparam int SH  = 4;
    localparam int RW  = 6;
    localparam int LAT = 1;
    localparam int CW  = 4;

    logic          clock_0 = 1'b0;
    logic          reset_0 = 1'b1;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [SH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic          rnd_valid, rnd_ready;
    logic [RW-1:0] rnd_data;
    logic [SH-1:0] g_a, g_b;
    logic [SH-1:0] g_z = 4'b0000;
    logic [RW-1:0] g_rand;
    logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [SH-1:0] rsp0_z, rsp1_z;
    logic [CW-1:0] starve_cnt;

    int total = 0;
    int bad   = 0;

    // reference model: per requester an outstanding flag and the cycle its result appears
    int cyc = 0;
    bit m_busy [2];
    int m_rdy  [2];
    bit m_val  [2];
    bit m_rr;
    int m_cnt;
    bit e_full [2];
    bit e_gv, e_gid, e_iss;

    logic          obs_r0, obs_r1, obs_v0;
    logic [SH-1:0] obs_z0, saved_z0;

    always #5 clock_0 = ~clock_0;

    hpc2_and_scheduler #(.SHARES(SH), .RAND_W(RW), .LAT(LAT), .CNT_W(CW)) dut (
        .clock_0(clock_0), .reset_0(reset_0),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_data(rnd_data),
        .g_a(g_a), .g_b(g_b), .g_rand(g_rand), .g_z(g_z),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_z(rsp0_z),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_z(rsp1_z),
        .starve_cnt(starve_cnt)
    );

    function automatic logic [SH-1:0] mk_z(logic [SH-1:0] a, logic [SH-1:0] b, logic [2:0] r);
        return {r, (^r) ^ ((^a) & (^b))};
    endfunction

    // Behavioural gadget: freshly re-masked product shares, one cycle later.
    always @(posedge clock_0) g_z <= mk_z(g_a, g_b, 3'($urandom));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic idle();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 4'b0000; req0_b = 4'b0000; req1_a = 4'b0000; req1_b = 4'b0000;
        rnd_valid = 1'b0; rnd_data = 6'h00;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    endtask

    task automatic step();
        bit            el [2];
        bit            v  [2];
        bit            rr [2];
        logic [SH-1:0] ea, eb;
        logic [RW-1:0] er;
        @(negedge clock_0);
        v[0] = req0_valid; v[1] = req1_valid;
        rr[0] = rsp0_ready; rr[1] = rsp1_ready;
        for (int i = 0; i < 2; i++) begin
            e_full[i] = m_busy[i] && (cyc >= m_rdy[i]);
            el[i] = v[i] && (!e_full[i] || rr[i]) && !(m_busy[i] && cyc < m_rdy[i]);
        end
        e_gv  = el[0] || el[1];
        e_gid = (el[0] && el[1]) ? m_rr : el[1];
        e_iss = e_gv && rnd_valid;
        ea = e_iss ? (e_gid ? req1_a : req0_a) : 4'b0000;
        eb = e_iss ? (e_gid ? req1_b : req0_b) : 4'b0000;
        er = e_iss ? rnd_data : 6'h00;
        chk("req0_ready", 32'(req0_ready), 32'(e_iss && !e_gid));
        chk("req1_ready", 32'(req1_ready), 32'(e_iss && e_gid));
        chk("rnd_ready", 32'(rnd_ready), 32'(e_iss));
        chk("g_a", 32'(g_a), 32'(ea));
        chk("g_b", 32'(g_b), 32'(eb));
        chk("g_rand", 32'(g_rand), 32'(er));
        chk("rsp0_valid", 32'(rsp0_valid), 32'(e_full[0]));
        chk("rsp1_valid", 32'(rsp1_valid), 32'(e_full[1]));
        if (e_full[0]) chk("rsp0_xor", 32'(^rsp0_z), 32'(m_val[0]));
        if (e_full[1]) chk("rsp1_xor", 32'(^rsp1_z), 32'(m_val[1]));
        chk("starve_cnt", 32'(starve_cnt), 32'(m_cnt));
        obs_r0 = req0_ready; obs_r1 = req1_ready; obs_v0 = rsp0_valid; obs_z0 = rsp0_z;
        @(posedge clock_0);
        for (int i = 0; i < 2; i++) if (e_full[i] && rr[i]) m_busy[i] = 1'b0;
        if (e_iss) begin
            m_busy[e_gid] = 1'b1;
            m_rdy[e_gid]  = cyc + LAT + 1;
            m_val[e_gid]  = e_gid ? ((^req1_a) & (^req1_b)) : ((^req0_a) & (^req0_b));
            m_rr = !e_gid;
        end else if (e_gv && m_cnt < (1 << CW) - 1) begin
            m_cnt++;
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset_0 = 1'b0;
        #1;
        chk("rst_req0_ready", 32'(req0_ready), 32'd0);
        chk("rst_req1_ready", 32'(req1_ready), 32'd0);
        chk("rst_rnd_ready", 32'(rnd_ready), 32'd0);
        chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
        chk("rst_g_a", 32'(g_a), 32'd0);
        chk("rst_g_b", 32'(g_b), 32'd0);
        chk("rst_g_rand", 32'(g_rand), 32'd0);
        chk("rst_rsp0_z", 32'(rsp0_z), 32'd0);
        chk("rst_rsp1_z", 32'(rsp1_z), 32'd0);
        chk("rst_starve", 32'(starve_cnt), 32'd0);
        m_busy[0] = 1'b0; m_busy[1] = 1'b0; m_rr = 1'b0; m_cnt = 0;
        @(posedge clock_0);
        @(posedge clock_0);
        #1;
        reset_0 = 1'b1;
    endtask

    initial begin
        idle();
        #2;
        do_reset();

        // single operation, then operands left on the bus without valid
        req0_valid = 1'b1; req0_a = 4'b0110; req0_b = 4'b1011;
        rnd_valid = 1'b1; rnd_data = 6'h2A;
        step();
        chk("single_issue", 32'({obs_r0, obs_r1}), 32'b10);
        req0_valid = 1'b0;
        step();
        step();
        chk("single_rsp", 32'(obs_v0), 32'd1);
        step();

        // contention: strict alternation from requester 0
        do_reset();
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 4'b0001; req0_b = 4'b0001; req1_a = 4'b0001; req1_b = 4'b0001;
        rnd_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            rnd_data = 6'(k + 5);
            step();
            chk("cont_grant", 32'({obs_r0, obs_r1}), (k % 2 == 0) ? 32'b10 : 32'b01);
        end
        idle();
        step(); step();

        // starvation must not move the pointer
        do_reset();
        req0_valid = 1'b1; req0_a = 4'b0011; req0_b = 4'b0111; rnd_valid = 1'b1;
        step();
        req0_valid = 1'b0; rnd_valid = 1'b0;
        step(); step();
        req0_valid = 1'b1; req1_valid = 1'b1; req1_a = 4'b1000; req1_b = 4'b0100;
        for (int k = 0; k < 5; k++) step();
        chk("starve5", 32'(starve_cnt), 32'd5);
        rnd_valid = 1'b1; rnd_data = 6'h11;
        step();
        chk("starve_grant1", 32'({obs_r0, obs_r1}), 32'b01);
        idle();
        step(); step(); step();

        // backpressure on response 0
        do_reset();
        req0_valid = 1'b1; req0_a = 4'b1110; req0_b = 4'b0010; rnd_valid = 1'b1;
        rsp0_ready = 1'b0;
        step();
        step();
        step();
        saved_z0 = obs_z0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_no_grant", 32'(obs_r0), 32'd0);
            chk("bp_z_stable", 32'(obs_z0), 32'(saved_z0));
        end
        rsp0_ready = 1'b1;
        step();
        chk("bp_release_issue", 32'(obs_r0), 32'd1);
        idle();
        step(); step(); step();

        // reset while an operation is in flight
        req1_valid = 1'b1; req1_a = 4'b0001; req1_b = 4'b0001; rnd_valid = 1'b1;
        step();
        do_reset();
        for (int k = 0; k < 4; k++) step();

        // saturation of the narrow counter
        req0_valid = 1'b1; rnd_valid = 1'b0;
        for (int k = 0; k < 20; k++) step();
        chk("starve_sat", 32'(starve_cnt), 32'd15);
        step();
        chk("starve_hold", 32'(starve_cnt), 32'd15);

        // randomized traffic
        do_reset();
        for (int k = 0; k < 800; k++) begin
            req0_valid = ($urandom_range(3, 0) != 0);
            req1_valid = ($urandom_range(3, 0) != 0);
            req0_a = 4'($urandom); req0_b = 4'($urandom);
            req1_a = 4'($urandom); req1_b = 4'($urandom);
            rnd_valid = ($urandom_range(3, 0) != 0);
            rnd_data = 6'($urandom);
            rsp0_ready = ($urandom_range(2, 0) != 0);
            rsp1_ready = ($urandom_range(2, 0) != 0);
            if ($urandom_range(99, 0) == 0) do_reset();
            else step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
